sar_compare_responder: RTL and testbench
========================================

SAR_COMPARE_RESPONDER -- requirements
Module: sar_compare_responder

Interface
REQ-001 The block SHALL have parameter DATA, default 8, giving the width of the value and target.
REQ-002 The block SHALL have parameter TIMEOUT, default 32, giving the maximum Clock cycles allowed in REQ or RUN.
REQ-003 Clock  input  1  system clock; all logic except Compare is rising-edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  one-cycle request to move the held value to Target.
REQ-006 Target  input  DATA  requested value; sampled only when Start is accepted.
REQ-007 ClockCmp  input  1  comparator strobe from the SAR controller.
REQ-008 StateP  input  2  controller state: 00 idle, 01 seed, 10 search, 11 flush.
REQ-009 SAROut  input  DATA  controller trial code.
REQ-010 Inc, Dcr  output  1 each  step-direction request to the controller.
REQ-011 Compare  output  1  comparator verdict: keep the current trial bit.
REQ-012 DataOut  output  DATA  held value, fed back to the controller.
REQ-013 Busy, Done, Match, Error  output  1 each  status flags.

Function
REQ-014 The FSM SHALL have four states: IDLE, REQ, RUN and DONE.
REQ-015 In IDLE, Start SHALL latch Target into TgtReg.
REQ-016 On Start in IDLE, the next state SHALL be DONE if Target==DataOut, else REQ.
REQ-017 Start SHALL be ignored in every state other than IDLE.
REQ-018 In REQ, Inc SHALL equal (TgtReg>DataOut) and Dcr SHALL equal (TgtReg<DataOut), unsigned, registered, and never both high.
REQ-019 Inc/Dcr SHALL stay asserted until a Clock edge samples StateP==01, which moves the FSM to RUN and clears Inc/Dcr on that same edge.
REQ-020 In RUN, Compare SHALL update on each rising ClockCmp edge to (SAROut <= TgtReg), unsigned.
REQ-021 Outside RUN, Compare SHALL be driven 0.
REQ-022 In RUN, the first Clock edge sampling StateP==00 SHALL load DataOut<=SAROut and move the FSM to DONE.
REQ-023 In DONE, Done SHALL be high for exactly one cycle and Match SHALL be registered as (DataOut==TgtReg); the next state SHALL be IDLE.
REQ-024 Match SHALL hold its value until the next accepted Start.
REQ-025 Busy SHALL be high in REQ and RUN only.
REQ-026 A cycle counter SHALL clear on entry to REQ and RUN, increment each cycle while in either state, and reaching TIMEOUT-1 SHALL force IDLE with Error=1.
REQ-027 On a timeout, Inc/Dcr SHALL be cleared and DataOut SHALL be unchanged; Error SHALL be sticky until the next accepted Start.
REQ-028 A controller return of StateP 01->11->00 with SAROut equal to the old value (target at rail) SHALL complete normally with Match=0.
REQ-029 Latency from Start to Done for an equal target SHALL be 1 cycle.

Reset
REQ-030 Reset SHALL force: state IDLE, DataOut=0, TgtReg=0, Inc=Dcr=0, Compare=0, Busy=Done=Match=Error=0, counter=0.
REQ-031 Reset asserted mid-operation SHALL abort immediately, with no Done pulse and DataOut=0.

Structure
REQ-032 The FSM state encoding and the StateP codes (00/01/10/11) SHALL be defined as constants in the shared SAR package, for use by both ends.
REQ-033 The unsigned magnitude comparator, used for both Compare and direction, SHALL be one sub-module, sar_mag_cmp.

Verification
REQ-034 The bench SHALL pair the block with the SAR controller, DATA=8, and cover:
- DataOut=0x00, Start Target=0x5A -> Inc one-shot; DataOut=0x5A within DATA+4 cycles; Done 1 cycle; Match=1.
- DataOut=0x5A, Start Target=0x13 -> Dcr asserted, Inc=0; final DataOut=0x13; Match=1.
- DataOut=0x3C, Start Target=0x3C -> no Inc/Dcr; Done the next cycle; Match=1; Busy never high.
- Controller StateP held at 00, Start Target=0x10 -> Error=1 after 31 cycles; DataOut unchanged; Inc released.
- Reset pulse during RUN -> all outputs 0 asynchronously; no Done; a later Start operates normally.
- Start re-pulsed while Busy with a different Target -> ignored; the result matches the first Target.

Source files
------------

// File: rtl/sar_compare_responder_pkg.sv
// Shared SAR constants used by the responder and by the SAR controller.
// - rspState_t : responder FSM encoding (IDLE, REQ, RUN, DONE)
// - SARP_*     : controller StateP codes seen on the link
package sar_compare_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } rspState_t;

    localparam logic [1:0] SARP_IDLE   = 2'b00;
    localparam logic [1:0] SARP_SEED   = 2'b01;
    localparam logic [1:0] SARP_SEARCH = 2'b10;
    localparam logic [1:0] SARP_FLUSH  = 2'b11;

endpackage

// File: rtl/sar_compare_responder_if.sv
// Link between the SAR controller (master) and the compare responder (slave).
// Controller drives: ClockCmp strobe, StateP, SAROut trial code.
// Responder drives : Inc/Dcr direction request, Compare verdict, DataOut held value.
interface sar_compare_responder_if #(
    parameter int DATA = 8
);
    logic            ClockCmp;
    logic [1:0]      StateP;
    logic [DATA-1:0] SAROut;
    logic            Inc;
    logic            Dcr;
    logic            Compare;
    logic [DATA-1:0] DataOut;

    modport master (
        output ClockCmp, StateP, SAROut,
        input  Inc, Dcr, Compare, DataOut
    );

    modport slave (
        input  ClockCmp, StateP, SAROut,
        output Inc, Dcr, Compare, DataOut
    );
endinterface

// File: rtl/sar_compare_responder_mag_cmp.sv
// Unsigned magnitude comparator. Ports: a, b in; lt (a<b), eq (a==b) out.
// a>b is derived by the user as !(lt|eq), so every output is always consumed.
module sar_mag_cmp #(
    parameter int DATA = 8
) (
    input  logic [DATA-1:0] a,
    input  logic [DATA-1:0] b,
    output logic            lt,
    output logic            eq
);
    assign lt = (a < b);
    assign eq = (a == b);
endmodule

// File: rtl/sar_compare_responder.sv
// Compare responder for a SAR controller: holds a value (DataOut), and on Start
// asks the controller to walk it to Target, answering the controller's trial
// codes with a keep/drop verdict on Compare.
// Ports:
//   Clock, Reset       : rising-edge clock, async active-high reset
//   Start, Target      : one-cycle request and the requested value
//   sar (slave)        : controller link (ClockCmp, StateP, SAROut / Inc, Dcr, Compare, DataOut)
//   Busy, Done, Match, Error : status flags
module sar_compare_responder
    import sar_compare_responder_pkg::*;
#(
    parameter int DATA    = 8,
    parameter int TIMEOUT = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [DATA-1:0]       Target,
    sar_compare_responder_if.slave sar,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Match,
    output logic                  Error
);
    localparam int CNT_W = $clog2(TIMEOUT);

    rspState_t       state, nextState;
    logic [DATA-1:0] dataReg, tgtReg;
    logic            incReg, dcrReg, matchReg, errReg, cmpReg, cmpOut;
    logic [CNT_W-1:0] cnt;
    logic            timeout;

    // Direction comparator: in IDLE it looks at the incoming Target so the
    // direction and the equal shortcut are ready on the Start edge itself;
    // afterwards it looks at the latched target (also gives Match in DONE).
    logic [DATA-1:0] dirA;
    logic            dirLt, dirEq, dirGt;
    assign dirA  = (state == ST_IDLE) ? Target : tgtReg;
    assign dirGt = !(dirLt || dirEq);

    sar_mag_cmp #(.DATA(DATA)) uDirCmp (.a(dirA), .b(dataReg), .lt(dirLt), .eq(dirEq));

    // Trial comparator: SAROut <= TgtReg keeps the current trial bit.
    logic cmpLt, cmpEq;
    sar_mag_cmp #(.DATA(DATA)) uTrialCmp (.a(sar.SAROut), .b(tgtReg), .lt(cmpLt), .eq(cmpEq));

    // Fires one count early so REQ+RUN never spend more than TIMEOUT-1 cycles.
    assign timeout = ((state == ST_REQ) || (state == ST_RUN)) && (cnt == CNT_W'(TIMEOUT - 2));

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= nextState;
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: if (Start) nextState = dirEq ? ST_DONE : ST_REQ;
            ST_REQ: begin
                if (timeout)                      nextState = ST_IDLE;
                else if (sar.StateP == SARP_SEED) nextState = ST_RUN;
            end
            ST_RUN: begin
                if (timeout)                      nextState = ST_IDLE;
                else if (sar.StateP == SARP_IDLE) nextState = ST_DONE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        Busy   = (state == ST_REQ) || (state == ST_RUN);
        Done   = (state == ST_DONE);
        cmpOut = (state == ST_RUN) && cmpReg;
    end

    // Datapath registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            dataReg  <= '0;
            tgtReg   <= '0;
            incReg   <= 1'b0;
            dcrReg   <= 1'b0;
            matchReg <= 1'b0;
            errReg   <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: if (Start) begin
                    tgtReg   <= Target;
                    incReg   <= dirGt;
                    dcrReg   <= dirLt;
                    matchReg <= 1'b0;
                    errReg   <= 1'b0;
                    cnt      <= '0;
                end
                ST_REQ: begin
                    if (timeout) begin
                        incReg <= 1'b0;
                        dcrReg <= 1'b0;
                        errReg <= 1'b1;
                    end else if (sar.StateP == SARP_SEED) begin
                        incReg <= 1'b0;
                        dcrReg <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        incReg <= dirGt;
                        dcrReg <= dirLt;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (timeout)                      errReg  <= 1'b1;
                    else if (sar.StateP == SARP_IDLE) dataReg <= sar.SAROut;
                    else                              cnt     <= cnt + CNT_W'(1);
                end
                default: matchReg <= dirEq;
            endcase
        end
    end

    // Verdict flop lives on the controller's strobe; gated to 0 outside RUN.
    always_ff @(posedge sar.ClockCmp or posedge Reset) begin
        if (Reset)                 cmpReg <= 1'b0;
        else if (state == ST_RUN)  cmpReg <= cmpLt || cmpEq;
    end

    assign sar.Inc     = incReg;
    assign sar.Dcr     = dcrReg;
    assign sar.Compare = cmpOut;
    assign sar.DataOut = dataReg;
    assign Match       = matchReg;
    assign Error       = errReg;
endmodule

// File: tb/tb_sar_compare_responder.sv
// Bench: responder paired with a behavioural SAR controller (DATA=8).
module tb_sar_compare_responder;
    import sar_compare_responder_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Start;
    logic [7:0] Target;
    logic       Busy, Done, Match, Error;

    sar_compare_responder_if #(.DATA(8)) sar ();

    sar_compare_responder #(.DATA(8), .TIMEOUT(32)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Target(Target),
        .sar(sar), .Busy(Busy), .Done(Done), .Match(Match), .Error(Error)
    );

    always #5 Clock = ~Clock;

    int   checks = 0;
    int   errors = 0;
    bit   ctlOn = 1'b1;
    bit   ctlStuck = 1'b0;
    logic [7:0] ctlCode;

    // waitDone results
    bit gotDone, sawBusy, sawBoth;
    int lat, nInc, nDcr;

    // Behavioural SAR controller: seed, 8-bit binary search on Compare, flush, idle.
    // Stuck mode returns the old value, as a controller pinned at a rail would.
    initial begin
        sar.StateP = SARP_IDLE; sar.SAROut = '0; sar.ClockCmp = 1'b0;
        forever begin
            @(posedge Clock); #1;
            if (ctlOn && (sar.Inc || sar.Dcr)) begin
                sar.StateP = SARP_SEED;
                @(posedge Clock); #1;
                ctlCode = '0;
                if (!ctlStuck) begin
                    sar.StateP = SARP_SEARCH;
                    for (int b = 7; b >= 0; b--) begin
                        sar.SAROut = ctlCode | (8'd1 << b);
                        #1 sar.ClockCmp = 1'b1;
                        #1 sar.ClockCmp = 1'b0;
                        if (sar.Compare) ctlCode = sar.SAROut;
                        @(posedge Clock); #1;
                    end
                end else begin
                    ctlCode = sar.DataOut;
                end
                sar.StateP = SARP_FLUSH; sar.SAROut = ctlCode;
                @(posedge Clock); #1;
                sar.StateP = SARP_IDLE;
            end
        end
    end

    task automatic doStart(input logic [7:0] t);
        @(posedge Clock); #2 Start = 1'b1; Target = t;
        @(posedge Clock); #1 Start = 1'b0;
    endtask

    // Samples each cycle (1 time unit after the edge) until Done, bounded.
    task automatic waitDone;
        gotDone = 0; sawBusy = 0; sawBoth = 0; lat = 0; nInc = 0; nDcr = 0;
        for (int i = 1; i <= 40 && !gotDone; i++) begin
            if (sar.Inc) nInc++;
            if (sar.Dcr) nDcr++;
            if (sar.Inc && sar.Dcr) sawBoth = 1;
            if (Busy) sawBusy = 1;
            if (Done) begin gotDone = 1; lat = i; end
            else begin @(posedge Clock); #1; end
        end
        checks++;
        if (!gotDone) begin errors++; $display("FAIL done_wait: no Done within 40 cycles"); end
    endtask

    task automatic test_reset;
        Reset = 1'b0; Start = 1'b0; Target = '0;
        #1 Reset = 1'b1;
        repeat (2) @(posedge Clock); #1;
        checks++;
        if ({sar.Inc, sar.Dcr, sar.Compare, Busy, Done, Match, Error} !== 7'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000000",
                {sar.Inc, sar.Dcr, sar.Compare, Busy, Done, Match, Error});
        end
        checks++;
        if (sar.DataOut !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", sar.DataOut); end
        @(negedge Clock) Reset = 1'b0;
    endtask

    task automatic test_up;
        doStart(8'h5A); waitDone;
        checks++; if (lat > 12) begin errors++; $display("FAIL up_latency: got %0d want <=12", lat); end
        checks++; if (nInc !== 1) begin errors++; $display("FAIL up_inc_oneshot: got %0d want 1", nInc); end
        checks++; if (nDcr !== 0 || sawBoth) begin errors++; $display("FAIL up_dcr: got %0d want 0", nDcr); end
        checks++; if (sar.DataOut !== 8'h5A) begin errors++; $display("FAIL up_data: got %h want 5a", sar.DataOut); end
        @(posedge Clock); #1;
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL up_done_width: got %b want 0", Done); end
        checks++; if (Match !== 1'b1) begin errors++; $display("FAIL up_match: got %b want 1", Match); end
        checks++; if (sar.Compare !== 1'b0) begin errors++; $display("FAIL up_cmp_idle: got %b want 0", sar.Compare); end
    endtask

    task automatic test_down;
        doStart(8'h13); waitDone;
        checks++; if (nDcr < 1) begin errors++; $display("FAIL down_dcr: got %0d want >=1", nDcr); end
        checks++; if (nInc !== 0 || sawBoth) begin errors++; $display("FAIL down_inc: got %0d want 0", nInc); end
        checks++; if (sar.DataOut !== 8'h13) begin errors++; $display("FAIL down_data: got %h want 13", sar.DataOut); end
        @(posedge Clock); #1;
        checks++; if (Match !== 1'b1) begin errors++; $display("FAIL down_match: got %b want 1", Match); end
    endtask

    task automatic test_equal;
        doStart(8'h3C); waitDone;
        checks++; if (sar.DataOut !== 8'h3C) begin errors++; $display("FAIL eq_setup_data: got %h want 3c", sar.DataOut); end
        repeat (2) @(posedge Clock);
        doStart(8'h3C); waitDone;
        checks++; if (lat !== 1) begin errors++; $display("FAIL eq_latency: got %0d want 1", lat); end
        checks++; if (nInc !== 0 || nDcr !== 0) begin errors++; $display("FAIL eq_dir: got inc %0d dcr %0d want 0 0", nInc, nDcr); end
        checks++; if (sawBusy) begin errors++; $display("FAIL eq_busy: got 1 want 0"); end
        @(posedge Clock); #1;
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL eq_done_width: got %b want 0", Done); end
        checks++; if (Match !== 1'b1) begin errors++; $display("FAIL eq_match: got %b want 1", Match); end
    endtask

    task automatic test_timeout;
        bit sawDone = 0;
        ctlOn = 1'b0;
        doStart(8'h10);
        for (int k = 1; k <= 30; k++) begin @(posedge Clock); #1; if (Done) sawDone = 1; end
        checks++; if (Error !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL to_early: got err %b busy %b want 0 1", Error, Busy); end
        checks++; if (sar.Dcr !== 1'b1) begin errors++; $display("FAIL to_dcr_held: got %b want 1", sar.Dcr); end
        @(posedge Clock); #1;
        checks++; if (Error !== 1'b1 || Busy !== 1'b0) begin errors++; $display("FAIL to_error: got err %b busy %b want 1 0", Error, Busy); end
        checks++; if (sar.Inc !== 1'b0 || sar.Dcr !== 1'b0) begin errors++; $display("FAIL to_release: got %b%b want 00", sar.Inc, sar.Dcr); end
        checks++; if (sar.DataOut !== 8'h3C || sawDone) begin errors++; $display("FAIL to_data: got %h done %b want 3c 0", sar.DataOut, sawDone); end
        repeat (3) @(posedge Clock); #1;
        checks++; if (Error !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", Error); end
        ctlOn = 1'b1;
    endtask

    task automatic test_rail;
        ctlStuck = 1'b1;
        doStart(8'h80);
        checks++; if (Error !== 1'b0) begin errors++; $display("FAIL rail_err_clear: got %b want 0", Error); end
        waitDone;
        checks++; if (sar.DataOut !== 8'h3C) begin errors++; $display("FAIL rail_data: got %h want 3c", sar.DataOut); end
        @(posedge Clock); #1;
        checks++; if (Match !== 1'b0) begin errors++; $display("FAIL rail_match: got %b want 0", Match); end
        ctlStuck = 1'b0;
    endtask

    task automatic test_back_to_back;
        doStart(8'h77);
        repeat (3) @(posedge Clock);
        doStart(8'h22);
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", Busy); end
        waitDone;
        checks++; if (sar.DataOut !== 8'h77) begin errors++; $display("FAIL b2b_data: got %h want 77", sar.DataOut); end
        @(posedge Clock); #1;
        checks++; if (Match !== 1'b1) begin errors++; $display("FAIL b2b_match: got %b want 1", Match); end
    endtask

    task automatic test_reset_mid_run;
        bit sawDone = 0;
        doStart(8'h40);
        repeat (4) @(posedge Clock); #1;
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", Busy); end
        #4 Reset = 1'b1;
        #1;
        checks++;
        if ({sar.Inc, sar.Dcr, sar.Compare, Busy, Done, Match, Error} !== 7'b0) begin
            errors++; $display("FAIL rst_async_flags: got %b want 0000000",
                {sar.Inc, sar.Dcr, sar.Compare, Busy, Done, Match, Error});
        end
        checks++; if (sar.DataOut !== 8'h00) begin errors++; $display("FAIL rst_async_data: got %h want 00", sar.DataOut); end
        @(posedge Clock);
        @(negedge Clock) Reset = 1'b0;
        for (int k = 0; k < 15; k++) begin @(posedge Clock); #1; if (Done) sawDone = 1; end
        checks++; if (sawDone) begin errors++; $display("FAIL rst_no_done: got 1 want 0"); end
        doStart(8'h21); waitDone;
        checks++; if (sar.DataOut !== 8'h21) begin errors++; $display("FAIL rst_after_data: got %h want 21", sar.DataOut); end
        @(posedge Clock); #1;
        checks++; if (Match !== 1'b1) begin errors++; $display("FAIL rst_after_match: got %b want 1", Match); end
    endtask

    initial begin
        test_reset;
        test_up;
        test_down;
        test_equal;
        test_timeout;
        test_rail;
        test_back_to_back;
        test_reset_mid_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
